// File: rtl/da_sample_pacer.sv
// Sample pacer feeding the serial distributed-arithmetic 8-tap FIR: buffers a
// valid/ready sample stream and presents one sample on X per PERIOD enabled clocks.
module da_sample_pacer #(
    parameter int DATA_W = 8,
    parameter int PERIOD = 9,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] X,
    output logic              x_strobe,
    output logic              x_valid,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underflow,
    output logic [CNT_W-1:0]  underflow_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PH_W  = $clog2(PERIOD);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [LVL_W-1:0]  level;
    logic [PH_W-1:0]   phase;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;

    // Ready looks only at the registered level, so a full FIFO refuses input
    // even in a cycle that pops.
    assign empty      = (level == '0);
    assign in_ready   = !Rst && (level < LVL_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign load       = enable && (phase == '0);
    assign pop        = load && !empty;
    assign fifo_level = level;

    // NOTE: the sample storage has no reset; emptying the FIFO is done by
    // clearing the pointers and level, so stale words are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, e.g. the pop reads the old head while
    // a same-edge push writes behind it.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            phase         <= '0;
            X             <= '0;
            x_strobe      <= 1'b0;
            x_valid       <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (enable) begin
                phase <= (phase == PH_W'(PERIOD - 1)) ? '0 : phase + PH_W'(1);
            end

            x_strobe  <= load;
            underflow <= load && empty;
            if (load) begin
                // An empty FIFO at a load zero-fills X rather than repeating
                // the previous sample.
                X       <= empty ? '0 : mem[rptr];
                x_valid <= !empty;
                if (empty && (underflow_cnt != '1)) begin
                    underflow_cnt <= underflow_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/da_sample_pacer.md
Name: da_sample_pacer

Overview:
- Upstream feeder for the serial distributed-arithmetic 8-tap FIR (SDA8FIR).
- Accepts signed 8-bit samples from a valid/ready stream into a small FIFO.
- Presents one sample on X, held stable for exactly PERIOD enabled clocks, which is the FIR's bit-serial processing window.
- Emits a strobe at each sample load and flags underflow when no sample is available.

Parameters:
- DATA_W, 8: sample width, signed two's complement.
- PERIOD, 9: clocks per FIR sample (8 bit-serial cycles + 1 accumulate/output cycle); legal range >= 2.
- DEPTH, 8: FIFO depth; power of 2, >= 2.
- CNT_W, 8: underflow counter width.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- enable  in  1  pacing enable; when low, phase counter and X freeze.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready.
- X  out  DATA_W  signed sample to FIR, registered.
- x_strobe  out  1  one-cycle pulse coincident with the first cycle a new X value is presented.
- x_valid  out  1  1 = X holds a real sample; 0 = zero-fill after underflow.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- underflow  out  1  one-cycle pulse when a load finds the FIFO empty.
- underflow_cnt  out  CNT_W  saturating count of underflow events.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - Effect on next edge: FIFO emptied (contents discarded), phase=0, X=0, x_strobe=0, x_valid=0, underflow=0, underflow_cnt=0, fifo_level=0.
  - in_ready=0 while Rst is high.
  - Reset mid-period or mid-transfer aborts immediately; no partial state survives.
- in_ready = !Rst && (fifo_level < DEPTH). This is combinational from registered count only. No push-through-pop when full: a full FIFO refuses input even in a pop cycle.
- Push: on an edge with in_valid && in_ready, in_data is written at the write pointer. Pointers wrap modulo DEPTH.
- Phase counter 0..PERIOD-1:
  - Advances only in cycles with enable=1; wraps PERIOD-1 -> 0.
  - enable=0 freezes phase, X, x_valid; strobes stay 0.
- Load event: in a cycle with enable=1 and phase==0. At the end of that cycle:
  - FIFO non-empty: X <= head, pop, x_valid <= 1, x_strobe <= 1 next cycle.
  - FIFO empty: X <= 0, x_valid <= 0, x_strobe <= 1, underflow <= 1 next cycle; underflow_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- First enabled cycle after reset is a load event. Loads then recur every PERIOD enabled cycles, so X is held exactly PERIOD enabled clocks.
- Simultaneous push and load, FIFO non-empty: level unchanged; head is the older sample.
- Simultaneous push and load, FIFO empty: no bypass. The load underflows and the pushed sample is presented at the next load.
- Latency: a sample pushed into an empty FIFO appears on X at the next load edge after the push edge, minimum 1 clock.
- Ordering is strict FIFO; no sample is ever dropped or duplicated.
- fifo_level updates on the same edge as push/pop: +1 push only, -1 pop only, unchanged for both or neither.

Test Plan:
- Basic pacing:
  - Stimulus: Rst, enable=0; push 10, -5, 127; then enable=1.
  - Response: X=10 for 9 clocks, then -5 for 9, then 127 for 9. x_strobe pulses exactly 9 clocks apart with x_valid=1. The fourth load gives X=0, x_valid=0, underflow pulse, underflow_cnt=1.
- Fill/back-pressure:
  - Stimulus: enable=0; hold in_valid=1 with values 1..10.
  - Response: exactly 8 accepted; in_ready=0 from the cycle fifo_level=8; samples 9 and 10 stay pending.
  - Stimulus: then enable=1.
  - Response: X sequence 1..8, and in_ready returns to 1 the cycle after the first pop.
- Freeze:
  - Stimulus: enable=1 with X=-128 loaded; drop enable for 5 clocks at phase 4.
  - Response: X stays -128, no strobe. The next load occurs 5 enabled clocks after re-enable (9 enabled clocks total).
- Simultaneous push/pop: FIFO at level 3, push on a load cycle -> fifo_level stays 3, order preserved. Empty FIFO with push on a load cycle -> underflow pulse; pushed value appears 9 enabled clocks later.
- Saturation: CNT_W=8, empty FIFO, enable=1 for 300 periods -> underflow_cnt=255 and holds.
- Reset mid-operation:
  - Stimulus: FIFO level 5, phase 6; assert Rst one clock.
  - Response: next edge gives fifo_level=0, X=0, x_valid=0, underflow_cnt=0. The first enabled clock after release is a load that underflows.
